// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus, decode reservation/query port and register-file write port
// of the register-file write arbiter.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic                          reserve_valid_i;
  logic [ADDR_WIDTH-1:0]         reserve_addr_i;
  logic [ADDR_WIDTH-1:0]         query_addr1_i;
  logic [ADDR_WIDTH-1:0]         query_addr2_i;
  logic                          pending1_o;
  logic                          pending2_o;
  logic                          RegWrite_o;
  logic [ADDR_WIDTH-1:0]         WriteAddr_o;
  logic [DATA_WIDTH-1:0]         WriteData_o;

  modport master (
    output req_valid_i, req_addr_i, req_data_i,
    output reserve_valid_i, reserve_addr_i, query_addr1_i, query_addr2_i,
    input  req_ready_o, pending1_o, pending2_o,
    input  RegWrite_o, WriteAddr_o, WriteData_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i,
    input  reserve_valid_i, reserve_addr_i, query_addr1_i, query_addr2_i,
    output req_ready_o, pending1_o, pending2_o,
    output RegWrite_o, WriteAddr_o, WriteData_o
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NUM_REQ
// writeback sources, with a per-register pending scoreboard for RAW hazard detection.
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  regfile_write_arbiter_if.slave bus
);
  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [PTR_W-1:0]      ptr_r;
  logic [PTR_W-1:0]      ptr_next_s;
  logic [PTR_W-1:0]      idx_s;
  logic [PTR_W-1:0]      grant_idx_s;
  logic [NUM_REQ-1:0]    grant_s;
  logic                  accept_s;
  logic [ADDR_WIDTH-1:0] acc_addr_s;
  logic [DATA_WIDTH-1:0] acc_data_s;
  logic [NUM_REGS-1:0]   pending_r;
  logic [NUM_REGS-1:0]   pending_next_s;
  logic                  reg_write_r;
  logic [ADDR_WIDTH-1:0] write_addr_r;
  logic [DATA_WIDTH-1:0] write_data_r;

  // Pick the first valid requester at or after the pointer, wrapping around
  always_comb begin
    grant_s     = '0;
    grant_idx_s = '0;
    accept_s    = 1'b0;
    idx_s       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s = PTR_W'((int'(ptr_r) + i) % NUM_REQ);
      if (!accept_s && bus.req_valid_i[idx_s]) begin
        accept_s           = 1'b1;
        grant_idx_s        = idx_s;
        grant_s[idx_s]     = 1'b1;
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
  end

  // Select the granted requester's address and data (grant is one-hot)
  always_comb begin
    acc_addr_s = '0;
    acc_data_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      acc_addr_s = acc_addr_s | ({ADDR_WIDTH{grant_s[k]}} & bus.req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]);
      acc_data_s = acc_data_s | ({DATA_WIDTH{grant_s[k]}} & bus.req_data_i[k*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Next pointer wraps after the last requester
  always_comb begin
    if (grant_idx_s == PTR_W'(NUM_REQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_idx_s + PTR_W'(1);
    end
  end

  // Scoreboard update: clear on accept, then set on reserve so a same-edge reservation wins
  always_comb begin
    pending_next_s = pending_r;
    if (accept_s) begin
      pending_next_s[acc_addr_s] = 1'b0;
    end else begin
      pending_next_s = pending_next_s;
    end
    if (bus.reserve_valid_i) begin
      pending_next_s[bus.reserve_addr_i] = 1'b1;
    end else begin
      pending_next_s = pending_next_s;
    end
    pending_next_s[0] = 1'b0;
  end

  // Pointer, registered write port and scoreboard state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r        <= '0;
      reg_write_r  <= 1'b0;
      write_addr_r <= '0;
      write_data_r <= '0;
      pending_r    <= '0;
    end else begin
      pending_r <= pending_next_s;
      if (accept_s) begin
        ptr_r        <= ptr_next_s;
        reg_write_r  <= (acc_addr_s != '0);
        write_addr_r <= acc_addr_s;
        write_data_r <= acc_data_s;
      end else begin
        reg_write_r  <= 1'b0;
      end
    end
  end

  assign bus.req_ready_o = rst ? '0 : grant_s;
  assign bus.pending1_o  = pending_r[bus.query_addr1_i];
  assign bus.pending2_o  = pending_r[bus.query_addr2_i];
  assign bus.RegWrite_o  = reg_write_r;
  assign bus.WriteAddr_o = write_addr_r;
  assign bus.WriteData_o = write_data_r;

endmodule
